// File: rtl/alu_unit_if.sv
// Purpose : operand/opcode/result bundle for alu_unit.
// Signals : Opcode      - operation select (4 bits)
//           alu_src1    - operand A
//           alu_src2    - operand B
//           Opcode_src3 - immediate shift/rotate amount (0..15)
//           td          - registered result
//           PSW         - registered flags {C, Z, V}
// Modports: master drives operation and operands, slave (the ALU) drives
//           td and PSW.
interface alu_unit_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       Opcode;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic [3:0]       Opcode_src3;
  logic [WIDTH-1:0] td;
  logic [2:0]       PSW;

  modport master (
    output Opcode, alu_src1, alu_src2, Opcode_src3,
    input  td, PSW
  );

  modport slave (
    input  Opcode, alu_src1, alu_src2, Opcode_src3,
    output td, PSW
  );
endinterface

// File: rtl/alu_unit.sv
// Purpose : 16-operation registered ALU. One operation per clock; the result
//           and the {C, Z, V} status word are registered, and the stored C
//           is the carry-in for ADC/SBB.
// Ports   : clk - rising-edge clock
//           rst - synchronous active-high reset (clears td and PSW)
//           bus - alu_unit_if.slave (Opcode, alu_src1, alu_src2,
//                 Opcode_src3 in; td, PSW out)
module alu_unit #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_unit_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_ADC = 4'd2,  OP_SBB = 4'd3,
    OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7,
    OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_SAR = 4'd10, OP_ROL = 4'd11,
    OP_ROR = 4'd12, OP_INC = 4'd13, OP_CMP = 4'd14, OP_MUL = 4'd15
  } op_e;

  logic [WIDTH-1:0]   r_td;
  logic [2:0]         r_psw;

  op_e                w_op;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [3:0]         w_sh;
  logic               w_cin;

  logic [WIDTH:0]     w_add;      // carry out in the top bit
  logic [WIDTH:0]     w_adc;
  logic [WIDTH:0]     w_sub;      // borrow in the top bit
  logic [WIDTH:0]     w_sbb;
  logic [WIDTH:0]     w_inc;
  logic [2*WIDTH-1:0] w_mul;
  logic [WIDTH:0]     w_shl_ext;  // bit WIDTH catches the last bit shifted out
  logic [WIDTH:0]     w_shr_ext;  // bit 0 catches the last bit shifted out
  logic [WIDTH:0]     w_sar_ext;
  logic [WIDTH-1:0]   w_rol;
  logic [WIDTH-1:0]   w_ror;

  logic [WIDTH-1:0]   w_result;
  logic               w_c;
  logic               w_v;
  logic               w_write_td;

  assign w_op  = op_e'(bus.Opcode);
  assign w_a   = bus.alu_src1;
  assign w_b   = bus.alu_src2;
  assign w_sh  = bus.Opcode_src3;
  assign w_cin = r_psw[2];

  assign w_add     = {1'b0, w_a} + {1'b0, w_b};
  assign w_adc     = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_sub     = {1'b0, w_a} - {1'b0, w_b};
  assign w_sbb     = {1'b0, w_a} - {1'b0, w_b} - {{WIDTH{1'b0}}, w_cin};
  assign w_inc     = {1'b0, w_a} + {{WIDTH{1'b0}}, 1'b1};
  assign w_mul     = w_a * w_b;
  assign w_shl_ext = {1'b0, w_a} << w_sh;
  assign w_shr_ext = {w_a, 1'b0} >> w_sh;
  assign w_sar_ext = $signed({w_a, 1'b0}) >>> w_sh;
  // A shift by WIDTH yields zero, so sh=0 degenerates cleanly to w_a.
  assign w_rol     = (w_a << w_sh) | (w_a >> (WIDTH - int'(w_sh)));
  assign w_ror     = (w_a >> w_sh) | (w_a << (WIDTH - int'(w_sh)));

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_result   = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    w_write_td = 1'b1;
    unique case (w_op)
      OP_ADD: begin
        w_result = w_add[WIDTH-1:0];
        w_c      = w_add[WIDTH];
        w_v      = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_result[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_ADC: begin
        w_result = w_adc[WIDTH-1:0];
        w_c      = w_adc[WIDTH];
        w_v      = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_result[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        w_result   = w_sub[WIDTH-1:0];
        w_c        = w_sub[WIDTH];
        w_v        = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_result[WIDTH-1] != w_a[WIDTH-1]);
        // CMP only updates flags; td keeps the previous result.
        w_write_td = (w_op == OP_SUB);
      end
      OP_SBB: begin
        w_result = w_sbb[WIDTH-1:0];
        w_c      = w_sbb[WIDTH];
        w_v      = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_result[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_AND: w_result = w_a & w_b;
      OP_OR:  w_result = w_a | w_b;
      OP_XOR: w_result = w_a ^ w_b;
      OP_NOT: w_result = ~w_a;
      OP_SHL: begin
        w_result = w_shl_ext[WIDTH-1:0];
        w_c      = w_shl_ext[WIDTH];
      end
      OP_SHR: begin
        w_result = w_shr_ext[WIDTH:1];
        w_c      = w_shr_ext[0];
      end
      OP_SAR: begin
        w_result = w_sar_ext[WIDTH:1];
        w_c      = w_sar_ext[0];
      end
      OP_ROL: begin
        w_result = w_rol;
        w_c      = (w_sh != 4'd0) && w_rol[0];
      end
      OP_ROR: begin
        w_result = w_ror;
        w_c      = (w_sh != 4'd0) && w_ror[WIDTH-1];
      end
      OP_INC: begin
        w_result = w_inc[WIDTH-1:0];
        w_c      = w_inc[WIDTH];
        w_v      = (w_a == {1'b0, {(WIDTH-1){1'b1}}});
      end
      OP_MUL: begin
        w_result = w_mul[WIDTH-1:0];
        w_c      = |w_mul[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_td  <= '0;
      r_psw <= '0;
    end else begin
      if (w_write_td) r_td <= w_result;
      r_psw <= {w_c, (w_result == '0), w_v};
    end
  end

  assign bus.td  = r_td;
  assign bus.PSW = r_psw;

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

  logic clk = 1'b0;
  logic rst;

  alu_unit_if #(.WIDTH(16)) u_if ();

  alu_unit #(.WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what td and PSW should hold.
  int m_td  = 0;
  int m_psw = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic int ovf16(input int s);
    return (s > 32767 || s < -32768) ? 1 : 0;
  endfunction

  // Behavioural model: plain integer arithmetic on the operation definitions.
  function automatic void ref_alu(input int op, input int a, input int b, input int sh,
                                  input int cin, output int res, output int c, output int v);
    int     sa = to_signed16(a);
    int     sb = to_signed16(b);
    int     s;
    longint p;
    c = 0;
    v = 0;
    case (op)
      0:  begin s = a + b;       res = s & 'hFFFF; c = (s > 65535); v = ovf16(sa + sb); end
      1, 14: begin s = a - b;    res = s & 'hFFFF; c = (a < b);     v = ovf16(sa - sb); end
      2:  begin s = a + b + cin; res = s & 'hFFFF; c = (s > 65535); v = ovf16(sa + sb + cin); end
      3:  begin s = a - b - cin; res = s & 'hFFFF; c = (a < b + cin); v = ovf16(sa - sb - cin); end
      4:  res = a & b;
      5:  res = a | b;
      6:  res = a ^ b;
      7:  res = (~a) & 'hFFFF;
      8:  begin res = (a << sh) & 'hFFFF; c = (sh != 0) ? ((a >> (16 - sh)) & 1) : 0; end
      9:  begin res = a >> sh;            c = (sh != 0) ? ((a >> (sh - 1)) & 1) : 0; end
      10: begin res = (sa >>> sh) & 'hFFFF; c = (sh != 0) ? ((a >> (sh - 1)) & 1) : 0; end
      11: begin res = ((a << sh) | (a >> (16 - sh))) & 'hFFFF; c = (sh != 0) ? (res & 1) : 0; end
      12: begin res = ((a >> sh) | (a << (16 - sh))) & 'hFFFF; c = (sh != 0) ? ((res >> 15) & 1) : 0; end
      13: begin s = a + 1; res = s & 'hFFFF; c = (a == 'hFFFF); v = (a == 'h7FFF); end
      default: begin p = longint'(a) * longint'(b); res = int'(p & 'hFFFF); c = ((p >> 16) != 0); end
    endcase
  endfunction

  // Issue one operation, advance one clock, update the model and compare.
  task automatic apply(input logic r, input int op, input int a, input int b, input int sh);
    int res, c, v;
    rst                = r;
    u_if.Opcode        = 4'(op);
    u_if.alu_src1      = 16'(a);
    u_if.alu_src2      = 16'(b);
    u_if.Opcode_src3   = 4'(sh);
    @(posedge clk);
    #1;
    if (r) begin
      m_td  = 0;
      m_psw = 0;
    end else begin
      ref_alu(op, a, b, sh, (m_psw >> 2) & 1, res, c, v);
      if (op != 14) m_td = res;
      m_psw = (c << 2) | ((res == 0) << 1) | v;
    end
    check($sformatf("op%0d_rst%0d_td", op, r), 32'(u_if.td), 32'(m_td));
    check($sformatf("op%0d_rst%0d_psw", op, r), 32'(u_if.PSW), 32'(m_psw));
  endtask

  // Hand-derived expectations for the directed scenarios.
  task automatic expect_out(input string tag, input int td, input int psw);
    check({tag, "_td"}, 32'(u_if.td), 32'(td));
    if (psw >= 0) check({tag, "_psw"}, 32'(u_if.PSW), 32'(psw));
  endtask

  function automatic int pick_operand();
    int corner [8] = '{'h0000, 'h0001, 'h7FFF, 'h8000, 'h8001, 'hFFFF, 'hFFFE, 'h00FF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 7)];
    return int'($urandom_range(0, 'hFFFF));
  endfunction

  initial begin
    rst              = 1'b0;
    u_if.Opcode      = '0;
    u_if.alu_src1    = '0;
    u_if.alu_src2    = '0;
    u_if.Opcode_src3 = '0;

    // Reset after arbitrary activity, then a zero add.
    apply(1'b1, 0, 0, 0, 0);
    apply(1'b0, 0, 'h1234, 'hF00F, 0);
    apply(1'b0, 15, 'hABCD, 'h0123, 3);
    apply(1'b1, 0, 'h5555, 'h5555, 0);     expect_out("reset", 'h0000, 'b000);
    apply(1'b0, 0, 'h0000, 'h0000, 0);     expect_out("add_zero", 'h0000, 'b010);

    // ADD/ADC carry chain and signed overflow.
    apply(1'b0, 0, 'hFFFF, 'h0001, 0);     expect_out("add_carry", 'h0000, 'b110);
    apply(1'b0, 2, 'h0001, 'h0001, 0);     expect_out("adc_cin", 'h0003, 'b000);
    apply(1'b0, 0, 'h7FFF, 'h0001, 0);     expect_out("add_ovf", 'h8000, 'b001);

    // CMP holds td; SUB borrow.
    apply(1'b0, 0, 'h1234, 'h0000, 0);
    apply(1'b0, 14, 'h0005, 'h0005, 0);    expect_out("cmp_hold", 'h1234, 'b010);
    apply(1'b0, 1, 'h0003, 'h0005, 0);     expect_out("sub_borrow", 'hFFFE, 'b100);
    apply(1'b0, 3, 'h0003, 'h0002, 0);     expect_out("sbb_cin", 'h0000, 'b010);

    // Shifts and rotates of 8001 by 1, then by 0.
    apply(1'b0, 8,  'h8001, 0, 1);         expect_out("shl", 'h0002, 'b100);
    apply(1'b0, 9,  'h8001, 0, 1);         expect_out("shr", 'h4000, 'b100);
    apply(1'b0, 10, 'h8001, 0, 1);         expect_out("sar", 'hC000, 'b100);
    apply(1'b0, 11, 'h8001, 0, 1);         expect_out("rol", 'h0003, 'b100);
    apply(1'b0, 12, 'h8001, 0, 1);         expect_out("ror", 'hC000, 'b100);
    apply(1'b0, 8,  'h8001, 0, 0);         expect_out("shl_zero", 'h8001, 'b000);
    apply(1'b0, 8,  'h0001, 0, 15);        expect_out("shl_15", 'h8000, 'b000);

    // Logic, INC, MUL.
    apply(1'b0, 4,  'hF0F0, 'h0F0F, 0);    expect_out("and", 'h0000, 'b010);
    apply(1'b0, 7,  'h0000, 'h1234, 5);    expect_out("not", 'hFFFF, 'b000);
    apply(1'b0, 13, 'hFFFF, 0, 0);         expect_out("inc_wrap", 'h0000, 'b110);
    apply(1'b0, 13, 'h7FFF, 0, 0);         expect_out("inc_ovf", 'h8000, 'b001);
    apply(1'b0, 15, 'h0100, 'h0100, 0);    expect_out("mul_hi", 'h0000, 'b110);
    apply(1'b0, 15, 'h0003, 'h0005, 0);    expect_out("mul_lo", 'h000F, 'b000);

    // Reset wins over an op in the same cycle; no carry survives.
    apply(1'b0, 0, 'hFFFF, 'h0001, 0);
    apply(1'b1, 0, 'hFFFF, 'h0001, 0);     expect_out("rst_mid", 'h0000, 'b000);
    apply(1'b0, 2, 'h0001, 'h0001, 0);     expect_out("adc_after_rst", 'h0002, -1);

    // Randomized stream against the model.
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 39) == 0), int'($urandom_range(0, 15)),
            pick_operand(), pick_operand(), int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
